// File: rtl/j68_arb_pkg.sv
// Shared types and constants for the J68 register-RAM port B arbiter.
package j68_arb_pkg;

  localparam int REG_DATA_W = 16;
  localparam int GAP_W      = 4;

  typedef enum logic [1:0] {
    CORE,
    FREE,
    STEAL,
    NONE
  } cycle_t;

  typedef enum logic {
    IDLE,
    RDCAP
  } rd_state_t;

endpackage

// File: rtl/j68_arb_gap_counter.sv
// Minimum-gap counter between stolen host slots: loads HOST_GAP on a steal,
// counts granted core cycles down to zero.
module j68_arb_gap_counter
  import j68_arb_pkg::*;
#(
  parameter int HOST_GAP = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic gap_zero
);

  logic [GAP_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= GAP_W'(HOST_GAP);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign gap_zero = (cnt == '0);

endmodule

// File: rtl/j68_regram_arbiter.sv
// Port B arbiter for the J68 microcode/register RAM: core vs host debug port.
// Optional steal counter built when J68_ARB_STEAL_CNT_EN is defined.
module j68_regram_arbiter
  import j68_arb_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int HOST_GAP = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_clken_in,
  output logic                  core_clken,
  output logic                  ram_clocken,
  output logic                  ram_rden_a,
  input  logic [1:0]            core_wren,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [REG_DATA_W-1:0] core_data,
  output logic [REG_DATA_W-1:0] core_q,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [1:0]            host_be,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [REG_DATA_W-1:0] host_wdata,
  output logic                  host_ack,
  output logic                  host_rvalid,
  output logic [REG_DATA_W-1:0] host_rdata,
  output logic [1:0]            ram_wren_b,
  output logic [ADDR_W-1:0]     ram_address_b,
  output logic [REG_DATA_W-1:0] ram_data_b,
  input  logic [REG_DATA_W-1:0] ram_q_b,
  output logic [15:0]           steal_cnt
);

  cycle_t    cyc;
  rd_state_t state_q, state_d;
  logic      gap_zero;
  logic      host_grant;
  logic      sel_shadow;
  logic [REG_DATA_W-1:0] shadow;

  // A request held through reset is dropped: reset forces an idle cycle.
  always_comb begin
    cyc = NONE;
    if (!reset) begin
      if (host_req && (!cpu_clken_in || gap_zero)) begin
        cyc = cpu_clken_in ? STEAL : FREE;
      end else if (cpu_clken_in) begin
        cyc = CORE;
      end
    end
  end

  assign host_grant = (cyc == FREE) || (cyc == STEAL);

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    core_clken    = 1'b0;
    ram_clocken   = 1'b0;
    ram_rden_a    = 1'b0;
    host_ack      = 1'b0;
    ram_wren_b    = 2'b00;
    ram_address_b = '0;
    ram_data_b    = '0;
    unique case (cyc)
      CORE: begin
        core_clken    = 1'b1;
        ram_clocken   = 1'b1;
        ram_rden_a    = 1'b1;
        ram_wren_b    = core_wren;
        ram_address_b = core_addr;
        ram_data_b    = core_data;
      end
      FREE, STEAL: begin
        ram_clocken   = 1'b1;
        host_ack      = 1'b1;
        ram_wren_b    = host_we ? host_be : 2'b00;
        ram_address_b = host_addr;
        ram_data_b    = host_wdata;
      end
      default: ;
    endcase
  end

  j68_arb_gap_counter #(
    .HOST_GAP (HOST_GAP)
  ) u_gap (
    .clock    (clock),
    .reset    (reset),
    .load     (cyc == STEAL),
    .dec      (cyc == CORE),
    .gap_zero (gap_zero)
  );

  // Read-capture FSM; a new read grant in RDCAP keeps it there, so
  // back-to-back reads each produce their own rvalid.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (host_grant && !host_we) state_d = RDCAP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= (state_q == RDCAP);
      if (state_q == RDCAP) host_rdata <= ram_q_b;
    end
  end

  // Core read-data shadow: keeps the core's last read visible while host
  // cycles overwrite the RAM output register.
  // NOTE: the shadow is a single register, not a memory, so it is reset too.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_shadow <= 1'b0;
      shadow     <= '0;
    end else if (host_grant && !sel_shadow) begin
      sel_shadow <= 1'b1;
      shadow     <= ram_q_b;
    end else if (cyc == CORE) begin
      sel_shadow <= 1'b0;
    end
  end

  assign core_q = reset ? '0 : (sel_shadow ? shadow : ram_q_b);

`ifdef J68_ARB_STEAL_CNT_EN
  logic [15:0] steal_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      steal_q <= '0;
    end else if ((cyc == STEAL) && (steal_q != 16'hFFFF)) begin
      steal_q <= steal_q + 16'd1;
    end
  end

  assign steal_cnt = steal_q;
`else
  assign steal_cnt = '0;
`endif

endmodule

// File: tb/tb_j68_regram_arbiter.sv
// Self-checking bench for j68_regram_arbiter: directed steps plus random
// traffic against a cycle-level behavioural model and a RAM model.
module tb_j68_regram_arbiter;

  localparam int ADDR_W   = 11;
  localparam int HOST_GAP = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_clken_in;
  logic              core_clken, ram_clocken, ram_rden_a;
  logic [1:0]        core_wren;
  logic [ADDR_W-1:0] core_addr;
  logic [15:0]       core_data, core_q;
  logic              host_req, host_we;
  logic [1:0]        host_be;
  logic [ADDR_W-1:0] host_addr;
  logic [15:0]       host_wdata;
  logic              host_ack, host_rvalid;
  logic [15:0]       host_rdata;
  logic [1:0]        ram_wren_b;
  logic [ADDR_W-1:0] ram_address_b;
  logic [15:0]       ram_data_b;
  logic [15:0]       ram_q_b = '0;
  logic [15:0]       steal_cnt;

  always #5 clock = ~clock;

  j68_regram_arbiter #(.ADDR_W(ADDR_W), .HOST_GAP(HOST_GAP)) dut (
    .clock(clock), .reset(reset), .cpu_clken_in(cpu_clken_in),
    .core_clken(core_clken), .ram_clocken(ram_clocken), .ram_rden_a(ram_rden_a),
    .core_wren(core_wren), .core_addr(core_addr), .core_data(core_data),
    .core_q(core_q), .host_req(host_req), .host_we(host_we), .host_be(host_be),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .ram_wren_b(ram_wren_b),
    .ram_address_b(ram_address_b), .ram_data_b(ram_data_b), .ram_q_b(ram_q_b),
    .steal_cnt(steal_cnt)
  );

  // Physical RAM port B: registered read, old data on read-during-write.
  logic [15:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_clocken) begin
      ram_q_b <= mem[ram_address_b];
      if (ram_wren_b[0]) mem[ram_address_b][7:0]  <= ram_data_b[7:0];
      if (ram_wren_b[1]) mem[ram_address_b][15:8] <= ram_data_b[15:8];
    end
  end

  // Reference model state.
  logic [15:0] ref_mem [DEPTH];
  int          gap_left, exp_steal, cyc_no;
  logic        core_seen;
  logic [15:0] last_core_rd;
  logic        rd1_v, exp_rvalid;
  logic [15:0] rd1_d, exp_rdata;
  int          total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    merge = old;
    if (be[0]) merge[7:0]  = d[7:0];
    if (be[1]) merge[15:8] = d[15:8];
  endfunction

  task automatic model_reset();
    gap_left = 0; exp_steal = 0; core_seen = 1'b0;
    rd1_v = 1'b0; rd1_d = '0; exp_rvalid = 1'b0; exp_rdata = '0;
  endtask

  task automatic set_host(input logic we, input logic [1:0] be,
                          input logic [ADDR_W-1:0] a, input logic [15:0] d);
    host_req = 1'b1; host_we = we; host_be = be; host_addr = a; host_wdata = d;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic do_cycle(input logic cpu, input logic [1:0] cwr, input logic [ADDR_W-1:0] ca);
    logic grant, steal, core_c, new_v;
    logic [15:0] new_d;
    int exp_sc;
    cpu_clken_in = cpu; core_wren = cwr; core_addr = ca;
    core_data = 16'($urandom);
    #1;
    steal  = host_req && cpu && (gap_left == 0);
    grant  = host_req && (!cpu || gap_left == 0);
    core_c = cpu && !grant;
`ifdef J68_ARB_STEAL_CNT_EN
    exp_sc = exp_steal;
`else
    exp_sc = 0;
`endif
    check("host_ack", host_ack, grant);
    check("core_clken", core_clken, core_c);
    check("ram_clocken", ram_clocken, grant || core_c);
    check("ram_rden_a", ram_rden_a, core_c);
    check("host_rvalid", host_rvalid, exp_rvalid);
    check("host_rdata", host_rdata, exp_rdata);
    check("steal_cnt", steal_cnt, exp_sc);
    if (core_seen) check("core_q", core_q, last_core_rd);
    if (grant) check("ram_wren_b", ram_wren_b, host_we ? host_be : 2'b00);
    @(posedge clock);
    new_v = 1'b0; new_d = '0;
    if (grant) begin
      if (!host_we) begin new_v = 1'b1; new_d = ref_mem[host_addr]; end
      else ref_mem[host_addr] = merge(ref_mem[host_addr], host_wdata, host_be);
      host_req = 1'b0;
    end
    if (steal) begin
      gap_left = HOST_GAP;
      if (exp_steal < 16'hFFFF) exp_steal++;
    end
    if (core_c) begin
      last_core_rd = ref_mem[ca];
      ref_mem[ca] = merge(ref_mem[ca], core_data, cwr);
      core_seen = 1'b1;
      if (gap_left > 0) gap_left--;
    end
    exp_rvalid = rd1_v;
    if (rd1_v) exp_rdata = rd1_d;
    rd1_v = new_v; rd1_d = new_d;
    cyc_no++;
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; cpu_clken_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_ack", host_ack, 1'b0);
      check("rst_core_clken", core_clken, 1'b0);
      check("rst_ram_clocken", ram_clocken, 1'b0);
      check("rst_ram_b", {ram_wren_b, ram_address_b, ram_data_b}, '0);
      if (i > 0) begin
        check("rst_rvalid", host_rvalid, 1'b0);
        check("rst_rdata", host_rdata, 16'h0);
        check("rst_core_q", core_q, 16'h0);
        check("rst_steal_cnt", steal_cnt, 16'h0);
        check("rst_rden_a", ram_rden_a, 1'b0);
      end
      @(negedge clock);
    end
    reset = 1'b0; host_req = 1'b0;
    model_reset();
  endtask

  initial begin
    int last_ack, ack_seen, diffs;
    logic [15:0] pre;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 16'($urandom); ref_mem[i] = mem[i];
    end
    mem[11'h123] = 16'hBEEF; ref_mem[11'h123] = 16'hBEEF;
    mem[11'h010] = 16'h1234; ref_mem[11'h010] = 16'h1234;
    mem[11'h020] = 16'hCAFE; ref_mem[11'h020] = 16'hCAFE;
    host_req = 0; host_we = 0; host_be = 0; host_addr = 0; host_wdata = 0;
    cpu_clken_in = 0; core_wren = 0; core_addr = 0; core_data = 0;
    cyc_no = 0; last_core_rd = '0; reset = 1'b1;
    @(negedge clock);
    do_reset(2);

    // Reset state with everything idle.
    do_cycle(1'b0, 2'b00, '0);

    // Core only.
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 2'b00, ADDR_W'($urandom));

    // FREE read of 0x123.
    set_host(1'b0, 2'b00, 11'h123, 16'h0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 2'b00, '0);
    check("free_rdata", host_rdata, 16'hBEEF);

    // STEAL write, low byte only, core_q held across the steal.
    for (int i = 0; i < HOST_GAP + 1; i++) do_cycle(1'b1, 2'b00, ADDR_W'(i));
    do_cycle(1'b1, 2'b00, 11'h020);
    set_host(1'b1, 2'b01, 11'h010, 16'h5A5A);
    do_cycle(1'b1, 2'b00, 11'h021);
    check("steal_core_q", core_q, 16'hCAFE);
    do_cycle(1'b1, 2'b00, 11'h022);
    check("steal_word", ref_mem[11'h010], 16'h125A);

    // Gap enforcement with the request held and the core always running.
    for (int i = 0; i < HOST_GAP + 1; i++) do_cycle(1'b1, 2'b00, ADDR_W'($urandom));
    last_ack = -1; ack_seen = 0;
    for (int i = 0; i < 3 * (HOST_GAP + 1) + 1; i++) begin
      if (!host_req) set_host(1'b1, 2'b11, ADDR_W'($urandom), 16'($urandom));
      #1;
      if (host_ack === 1'b1) begin
        if (last_ack >= 0) check("gap_spacing", cyc_no - last_ack, HOST_GAP + 1);
        last_ack = cyc_no; ack_seen++;
      end
      #0;
      do_cycle(1'b1, 2'b00, ADDR_W'($urandom));
    end
    check("gap_ack_count", ack_seen, 4);
    host_req = 1'b0;

    // No-op write: acked, no RAM change, no rvalid.
    pre = ref_mem[11'h123];
    set_host(1'b1, 2'b00, 11'h123, 16'h0000);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 2'b00, '0);
    check("noop_word", mem[11'h123], pre);

    // Back-to-back FREE reads, then random mixed traffic.
    for (int i = 0; i < 4; i++) begin
      set_host(1'b0, 2'b00, ADDR_W'($urandom), 16'h0);
      do_cycle(1'b0, 2'b00, '0);
    end
    for (int i = 0; i < 400; i++) begin
      if (!host_req && ($urandom_range(0, 2) != 0))
        set_host(1'($urandom), 2'($urandom), ADDR_W'($urandom), 16'($urandom));
      do_cycle(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
               ADDR_W'($urandom));
    end
    host_req = 1'b0;
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 2'b00, '0);

    // Reset one cycle after a read ack; request held during reset is dropped.
    set_host(1'b0, 2'b00, 11'h123, 16'h0);
    do_cycle(1'b0, 2'b00, '0);
    host_req = 1'b1;
    do_reset(2);
    do_cycle(1'b0, 2'b00, '0);
    check("post_reset_steal", steal_cnt, 16'h0);

    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("ram_contents", diffs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/j68_regram_arbiter.md
# j68_regram_arbiter

Arbitrates port B of the J68 microcode/register dual-port RAM between the CPU core and a host debug port that reads and writes m68k registers and RAM words. The arbiter owns the RAM clock enable. Host accesses use idle cycles when they are available. Otherwise the arbiter steals one core cycle, bounded by a minimum core-cycle gap. It sits between the J68 core, the 2048-word RAM, and the debug/loader bridge.

## Interface
- ADDR_W, 11: port B address width.
- HOST_GAP, 4: minimum granted core cycles between two stolen host slots; range 1..15.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_clken_in  in  1  core requests an execution cycle.
- core_clken  out  1  core advances this cycle.
- ram_clocken  out  1  RAM clock enable.
- ram_rden_a  out  1  microcode fetch enable; low holds q_a.
- core_wren  in  2  core byte write enables.
- core_addr  in  ADDR_W  core register address.
- core_data  in  16  core write data.
- core_q  out  16  core read data.
- host_req  in  1  host access request; held until ack.
- host_we  in  1  host write.
- host_be  in  2  host byte enables.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  16  host write data.
- host_ack  out  1  one-cycle pulse; the access is issued this cycle.
- host_rvalid  out  1  one-cycle pulse; host_rdata is valid.
- host_rdata  out  16  host read data.
- ram_wren_b  out  2  RAM port B byte write enables.
- ram_address_b  out  ADDR_W  RAM port B address.
- ram_data_b  out  16  RAM port B write data.
- ram_q_b  in  16  RAM port B read data (registered, latency 1).
- steal_cnt  out  16  count of stolen core cycles.

## Operation
- **Cycle types:** each cycle is exactly one of CORE, FREE or STEAL.
  - CORE: no host grant and cpu_clken_in=1. ram_clocken=1, core_clken=1, ram_rden_a=1, port B driven from the core.
  - FREE: host_req=1, cpu_clken_in=0. The host owns port B. ram_clocken=1, core_clken=0, ram_rden_a=0.
  - STEAL: host_req=1, cpu_clken_in=1, gap counter = 0. Same port B drive as FREE. The core is held with core_clken=0.
  - Otherwise with cpu_clken_in=0 and no host_req: ram_clocken=0 and all enables are 0.
- **Host grants:**
  - FREE and STEAL cycles pulse host_ack.
  - ram_wren_b = host_we ? host_be : 2'b00.
  - host_we=1 with host_be=00 is acked as a no-op and produces no rvalid.
- **Gap counter:**
  - Loads HOST_GAP on every STEAL cycle.
  - Decrements on each CORE cycle while nonzero.
  - FREE cycles do not load it.
- **Core read-data shadow:**
  - At the end of a host cycle (FREE or STEAL) with sel_shadow=0: shadow<=ram_q_b and sel_shadow<=1.
  - At the end of a CORE cycle: sel_shadow<=0.
  - core_q = sel_shadow ? shadow : ram_q_b.
- **State machine:** states IDLE and RDCAP.
  - A host read grant moves the FSM to RDCAP for one cycle.
  - In RDCAP: host_rdata<=ram_q_b at the end of the cycle, and host_rvalid=1 in the following cycle.
  - RDCAP overlaps freely with the next CORE or host cycle.
- **Back-to-back host grants** are legal in FREE cycles, and ack is reasserted each cycle. Each host read produces its own rvalid in order.
- **Reset:**
  - Values: all outputs 0, gap counter 0, sel_shadow 0, shadow 0, FSM IDLE.
  - Mid-operation: a pending request is dropped with no ack, and pending rvalid is cancelled.

## Timing
- Host slot at cycle T:
  - host_ack is high in T.
  - For reads, ram_q_b carries the host data in T+1, and host_rvalid/host_rdata are high in T+2.
- After a STEAL at T, the earliest next STEAL is at T+HOST_GAP+1, assuming continuous core requests.
- core_q holds the core's last read value through any run of host cycles. It returns to ram_q_b after the next CORE cycle completes.
- host_ack, ram_* and core_clken are combinational from the inputs and registered state. host_rvalid and host_rdata are registered.

## Configuration
- Macro: J68_ARB_STEAL_CNT_EN.
- Defined: steal_cnt is a 16-bit saturating counter that increments on each STEAL cycle and is cleared by reset; saturates at 16'hFFFF.
- Undefined: steal_cnt is tied to 0 and no counter logic is built.

## Structure
- Shared package j68_arb_pkg holds:
  - cycle-type enum (CORE, FREE, STEAL, NONE);
  - FSM state enum (IDLE, RDCAP);
  - constant REG_DATA_W=16;
  - constant GAP_W=4.
- One sub-module, j68_arb_gap_counter: load/decrement/zero-flag, parameterised by HOST_GAP.

## Test plan
- **Core only:** cpu_clken_in=1 continuously, no host traffic.
  - ram_clocken=core_clken=ram_rden_a=1 every cycle.
  - core_q tracks ram_q_b.
- **FREE read:** cpu_clken_in=0, host read at addr 0x123 preloaded with 0xBEEF.
  - ack at T, rvalid at T+2 with 0xBEEF.
  - core_clken=0, ram_rden_a=0, steal_cnt unchanged.
- **STEAL write:** cpu_clken_in=1, host write of 0x5A5A with be=01 at addr 0x010.
  - core_clken=0 for one cycle.
  - Only the low byte of the word changes.
  - core_q equals the pre-steal value until the next CORE cycle ends.
- **Gap enforcement:** HOST_GAP=4, host_req held high with cpu_clken_in=1.
  - Acks land at cycles T, T+5, T+10, …
  - steal_cnt increments by 1 per ack.
- **No-op write:** host_we=1, host_be=00 → ack, no RAM change, no rvalid.
- **Reset mid-read:** reset asserted at T+1 after a host read ack.
  - No rvalid.
  - All outputs 0 at T+2.
  - steal_cnt=0.
